// File: rtl/obi_mp_sram_responder.sv
// obi_mp_sram_responder: multi-port OBI responder backed by a word-addressed
// SRAM with byte enables. Round-robin arbitration, one transaction in flight,
// response WAIT_CYCLES+1 cycles after the grant edge.

package obi_mp_sram_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module obi_mp_sram_responder
    import obi_mp_sram_pkg::*;
#(
    parameter int NHARTS      = 3,
    parameter int NUM_WORDS   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  obi_req_t  [NHARTS-1:0] obi_req_i,
    output obi_resp_t [NHARTS-1:0] obi_resp_o
);

    localparam int PW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam int AW = $clog2(NUM_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // Reject parameter values the datapath cannot represent.
    if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_words
        $error("NUM_WORDS must be a power of two and at least 2");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be within 0..15");
    end
    if (NHARTS < 1) begin : g_bad_harts
        $error("NHARTS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [PW-1:0]     ptr, ptr_d;
    logic [PW-1:0]     owner;
    logic [31:0]       rdata_q;

    logic [PW-1:0]     win;
    logic              found;
    logic              eligible;
    logic              grant;
    obi_req_t          sel;
    logic [AW-1:0]     idx;

    logic [31:0]       mem [NUM_WORDS];

    // Address bits that never reach the array; kept only to document that
    // they are intentionally ignored (addresses alias modulo NUM_WORDS*4).
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{sel.addr[31:2+AW], sel.addr[1:0]};

    // A grant can only be issued out of reset while no response is pending
    // beyond the current cycle; RESP is eligible so transfers can run back-to-back.
    assign eligible = rst_ni && ((state == IDLE) || (state == RESP));
    assign grant    = eligible && found;
    assign sel      = obi_req_i[win];
    assign idx      = sel.addr[2 +: AW];

    // Round-robin scan: first requesting port starting at ptr, wrapping mod NHARTS.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NHARTS; i++) begin
            int            cand;
            logic [PW-1:0] cand_idx;
            cand = int'(ptr) + i;
            if (cand >= NHARTS) begin
                cand = cand - NHARTS;
            end
            cand_idx = PW'(cand);
            if (!found && obi_req_i[cand_idx].req) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    // Next-state logic: WAIT counts down, RESP lasts one cycle, and a grant
    // always (re)starts the latency sequence from the granting state.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ptr_d   = ptr;
        case (state)
            IDLE: begin
                state_d = IDLE;
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (grant) begin
            ptr_d = (win == PW'(NHARTS - 1)) ? '0 : win + PW'(1);
            if (WAIT_CYCLES == 0) begin
                state_d = RESP;
            end else begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end
        end
    end

    // Control registers and the captured response word.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ptr     <= '0;
            owner   <= '0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ptr   <= ptr_d;
            if (grant) begin
                owner   <= win;
                // Write responses carry zero; reads capture the whole word
                // before this edge's write, which only affects writes anyway.
                rdata_q <= sel.we ? 32'h0 : mem[idx];
            end
        end
    end

    // Byte-enabled array write at the grant edge; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        if (grant && sel.we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel.be[b]) begin
                    mem[idx][8*b +: 8] <= sel.wdata[8*b +: 8];
                end
            end
        end
    end

    // Per-port response fan-out: gnt to the winner, rvalid/rdata to the owner only.
    always_comb begin
        for (int p = 0; p < NHARTS; p++) begin
            obi_resp_o[p].gnt    = grant && (win == PW'(p));
            obi_resp_o[p].rvalid = (state == RESP) && (owner == PW'(p));
            obi_resp_o[p].rdata  = ((state == RESP) && (owner == PW'(p))) ? rdata_q : 32'h0;
        end
    end

endmodule

// File: tb/tb_obi_mp_sram_responder.sv
// Testbench for obi_mp_sram_responder: three instances with WAIT_CYCLES 0, 2, 3.
module tb_obi_mp_sram_responder;
    import obi_mp_sram_pkg::*;

    localparam int NH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0, rst_n2, rst_n3;
    obi_req_t  [NH-1:0] req0, req2, req3;
    obi_resp_t [NH-1:0] resp0, resp2, resp3;

    obi_mp_sram_responder #(.NHARTS(NH), .NUM_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .rst_ni(rst_n0), .obi_req_i(req0), .obi_resp_o(resp0)
    );
    obi_mp_sram_responder #(.NHARTS(NH), .NUM_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
        .clk_i(clk), .rst_ni(rst_n2), .obi_req_i(req2), .obi_resp_o(resp2)
    );
    obi_mp_sram_responder #(.NHARTS(NH), .NUM_WORDS(256), .WAIT_CYCLES(3)) u_w3 (
        .clk_i(clk), .rst_ni(rst_n3), .obi_req_i(req3), .obi_resp_o(resp3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    function automatic logic [31:0] gnts(input obi_resp_t [NH-1:0] r);
        logic [31:0] v;
        v = '0;
        for (int p = 0; p < NH; p++) v[p] = r[p].gnt;
        return v;
    endfunction

    function automatic logic [31:0] rvs(input obi_resp_t [NH-1:0] r);
        logic [31:0] v;
        v = '0;
        for (int p = 0; p < NH; p++) v[p] = r[p].rvalid;
        return v;
    endfunction

    function automatic obi_req_t mk(input logic we, input logic [3:0] be,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        obi_req_t r;
        r.req   = 1'b1;
        r.we    = we;
        r.be    = be;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rr_data [NH];

    initial begin
        vec[0]  = '{0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0};
        vec[1]  = '{0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
        vec[2]  = '{1, 1'b1, 4'hF, 32'h0000_0020, 32'h11223344, 32'h0};
        vec[3]  = '{2, 1'b1, 4'h5, 32'h0000_0020, 32'hAABBCCDD, 32'h0};
        vec[4]  = '{1, 1'b0, 4'hF, 32'h0000_0020, 32'h0,        32'h11BB33DD};
        vec[5]  = '{2, 1'b1, 4'hF, 32'h0000_0004, 32'h5A5A5A5A, 32'h0};
        vec[6]  = '{0, 1'b0, 4'hF, 32'h0000_0404, 32'h0,        32'h5A5A5A5A};
        vec[7]  = '{1, 1'b0, 4'hF, 32'h0000_0013, 32'h0,        32'hDEADBEEF};
        vec[8]  = '{2, 1'b1, 4'hF, 32'h0000_0030, 32'h01020304, 32'h0};
        vec[9]  = '{0, 1'b1, 4'hA, 32'h0000_0030, 32'hFFFFFFFF, 32'h0};
        vec[10] = '{1, 1'b1, 4'h0, 32'h0000_0030, 32'h00000000, 32'h0};
        vec[11] = '{2, 1'b0, 4'h0, 32'h0000_0030, 32'h0,        32'hFF02FF04};
        vec[12] = '{0, 1'b0, 4'hF, 32'hFFFF_FC30, 32'h0,        32'hFF02FF04};

        req0 = '0; req2 = '0; req3 = '0;
        rst_n0 = 1'b0; rst_n2 = 1'b0; rst_n3 = 1'b0;
        step();
        step();

        // Reset state: requests pending on every port, nothing granted or returned.
        for (int p = 0; p < NH; p++) begin
            req0[p] = mk(1'b0, 4'hF, 32'h0, 32'h0);
            req2[p] = mk(1'b0, 4'hF, 32'h0, 32'h0);
            req3[p] = mk(1'b0, 4'hF, 32'h0, 32'h0);
        end
        @(negedge clk);
        check("rst_gnt_w0", gnts(resp0), 32'h0);
        check("rst_gnt_w2", gnts(resp2), 32'h0);
        check("rst_gnt_w3", gnts(resp3), 32'h0);
        check("rst_rvalid_w0", rvs(resp0), 32'h0);
        for (int p = 0; p < NH; p++) check($sformatf("rst_rdata_p%0d", p), resp0[p].rdata, 32'h0);
        step();
        req0 = '0; req2 = '0; req3 = '0;
        rst_n0 = 1'b1; rst_n2 = 1'b1; rst_n3 = 1'b1;
        @(negedge clk);
        check("idle_rvalid_w0", rvs(resp0), 32'h0);
        step();

        // Single-port transactions on the zero-wait instance.
        for (int i = 0; i < NV; i++) begin
            req0 = '0;
            req0[vec[i].port] = mk(vec[i].we, vec[i].be, vec[i].addr, vec[i].wdata);
            @(negedge clk);
            check($sformatf("v%0d_gnt", i), gnts(resp0), 32'(1) << vec[i].port);
            check($sformatf("v%0d_rvalid_idle", i), rvs(resp0), 32'h0);
            step();
            req0 = '0;
            @(negedge clk);
            check($sformatf("v%0d_rvalid", i), rvs(resp0), 32'(1) << vec[i].port);
            check($sformatf("v%0d_rdata", i), resp0[vec[i].port].rdata, vec[i].exp_rdata);
            check($sformatf("v%0d_gnt_resp", i), gnts(resp0), 32'h0);
            step();
        end

        // Round-robin with all ports requesting every cycle after a fresh reset.
        rst_n0 = 1'b0;
        step();
        rst_n0 = 1'b1;
        rr_data[0] = 32'hDEADBEEF;
        rr_data[1] = 32'h11BB33DD;
        rr_data[2] = 32'h5A5A5A5A;
        req0[0] = mk(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        req0[1] = mk(1'b0, 4'hF, 32'h0000_0020, 32'h0);
        req0[2] = mk(1'b0, 4'hF, 32'h0000_0004, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rr%0d_gnt", c), gnts(resp0), 32'(1) << (c % 3));
            if (c == 0) begin
                check("rr0_rvalid", rvs(resp0), 32'h0);
            end else begin
                check($sformatf("rr%0d_rvalid", c), rvs(resp0), 32'(1) << ((c - 1) % 3));
                check($sformatf("rr%0d_rdata", c), resp0[(c - 1) % 3].rdata, rr_data[(c - 1) % 3]);
            end
            step();
        end
        req0 = '0;
        @(negedge clk);
        check("rr_last_rvalid", rvs(resp0), 32'h4);
        check("rr_last_rdata", resp0[2].rdata, rr_data[2]);
        step();

        // Read-after-write on consecutive grants.
        req0[0] = mk(1'b1, 4'hF, 32'h0000_0050, 32'h13579BDF);
        @(negedge clk);
        check("raw_wr_gnt", gnts(resp0), 32'h1);
        step();
        req0 = '0;
        req0[1] = mk(1'b0, 4'hF, 32'h0000_0050, 32'h0);
        @(negedge clk);
        check("raw_rd_gnt", gnts(resp0), 32'h2);
        check("raw_wr_rvalid", rvs(resp0), 32'h1);
        check("raw_wr_rdata", resp0[0].rdata, 32'h0);
        step();
        req0 = '0;
        @(negedge clk);
        check("raw_rd_rvalid", rvs(resp0), 32'h2);
        check("raw_rd_rdata", resp0[1].rdata, 32'h13579BDF);
        check("raw_other_rdata", resp0[0].rdata, 32'h0);
        step();

        // Two wait cycles: gnt at N, quiet N+1..N+2, rvalid plus new grant at N+3.
        req2[0] = mk(1'b1, 4'hF, 32'h0000_0008, 32'h0BADCAFE);
        @(negedge clk);
        check("w2_gnt_n", gnts(resp2), 32'h1);
        step();
        req2 = '0;
        req2[1] = mk(1'b0, 4'hF, 32'h0000_0008, 32'h0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check($sformatf("w2_gnt_n%0d", k), gnts(resp2), 32'h0);
            check($sformatf("w2_rvalid_n%0d", k), rvs(resp2), 32'h0);
            step();
        end
        @(negedge clk);
        check("w2_rvalid_n3", rvs(resp2), 32'h1);
        check("w2_rdata_n3", resp2[0].rdata, 32'h0);
        check("w2_gnt_n3", gnts(resp2), 32'h2);
        step();
        req2 = '0;
        for (int k = 4; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("w2_gnt_n%0d", k), gnts(resp2), 32'h0);
            check($sformatf("w2_rvalid_n%0d", k), rvs(resp2), 32'h0);
            step();
        end
        @(negedge clk);
        check("w2_rvalid_n6", rvs(resp2), 32'h2);
        check("w2_rdata_n6", resp2[1].rdata, 32'h0BADCAFE);
        step();

        // Reset in the middle of a three-wait read: the response is dropped
        // and the pointer returns to port 0.
        req3[1] = mk(1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        check("w3_gnt_n", gnts(resp3), 32'h2);
        step();
        req3 = '0;
        @(negedge clk);
        check("w3_gnt_n1", gnts(resp3), 32'h0);
        step();
        rst_n3 = 1'b0;
        @(negedge clk);
        check("w3_gnt_rst", gnts(resp3), 32'h0);
        check("w3_rvalid_rst", rvs(resp3), 32'h0);
        step();
        rst_n3 = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("w3_rvalid_n%0d", k), rvs(resp3), 32'h0);
            step();
        end
        for (int p = 0; p < NH; p++) req3[p] = mk(1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        check("w3_ptr_reset_gnt", gnts(resp3), 32'h1);
        step();
        req3 = '0;
        for (int k = 7; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("w3_rvalid_n%0d", k), rvs(resp3), 32'h0);
            check($sformatf("w3_gnt_n%0d", k), gnts(resp3), 32'h0);
            step();
        end
        @(negedge clk);
        check("w3_rvalid_n10", rvs(resp3), 32'h1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
